// File: rtl/lut_ram_pkg.sv
// Shared constants and types for the two-port LUT RAM and its clear controller.
package lut_ram_pkg;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } clear_state_e;

endpackage

// File: rtl/lut_ram_clear_ctrl.sv
// Post-reset zero-fill sequencer: walks addresses 0..DEPTH-1, one per cycle, holding busy high.
module lut_ram_clear_ctrl
  import lut_ram_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CLEAR_ON_RST = 1,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  clear_state_e  state_q;
  logic [AW-1:0] cnt_q;
  logic          start_q;

  // start_q remembers that a reset happened so the clear begins on the first edge after release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      start_q <= (CLEAR_ON_RST != 0);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_q) begin
            state_q <= StClear;
            start_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        StClear: begin
          if (cnt_q == LastAddr) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = (state_q == StClear);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/lut_ram_2port.sv
// One-write/one-read LUT RAM with byte enables, selectable read-during-write behaviour,
// optional output register and an optional post-reset zero-fill.
module lut_ram_2port
  import lut_ram_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 16384,
  parameter int unsigned RDW_MODE     = 0,
  parameter int unsigned OUT_REG      = 0,
  parameter int unsigned CLEAR_ON_RST = 1,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  output logic               busy
);

  localparam int NB = WIDTH / 8;
  localparam logic [AW:0] DepthLim = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          wr_acc;
  logic          rd_acc;
  logic [WIDTH-1:0] rd_word;

  lut_ram_clear_ctrl #(
    .DEPTH        (DEPTH),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Addresses beyond DEPTH only exist when DEPTH is not a power of two; they are dropped.
  assign wr_acc = wr_en & ~busy & rst & ({1'b0, wr_addr} < DepthLim);
  assign rd_acc = rd_en & ~busy & rst & ({1'b0, rd_addr} < DepthLim);

  // No reset on the array so it stays mappable to distributed RAM.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_MODE == RDW_WRITE_FIRST && wr_acc && (wr_addr == rd_addr)) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          rd_word[8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_acc;
      if (rd_acc) begin
        s1_data_q <= rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_data  = s2_data_q;
  end else begin : g_no_out_reg
    assign rd_valid = s1_valid_q;
    assign rd_data  = s1_data_q;
  end

endmodule

// File: doc/lut_ram_2port.md
LUT_RAM_2PORT -- requirements
Module: lut_ram_2port

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 16384: number of words; must be at least 2.
REQ-003 SHALL have parameter RDW_MODE, default 0: same-address read-during-write behaviour; 0 = read-first (old data), 1 = write-first (new data).
REQ-004 SHALL have parameter OUT_REG, default 0: 1 adds one output register stage.
REQ-005 SHALL have parameter CLEAR_ON_RST, default 1: 1 zero-fills the whole array after reset.
REQ-006 SHALL provide clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL provide rst, input, 1: reset, synchronous and active-low.
REQ-008 SHALL provide wr_en, input, 1: write request.
REQ-009 SHALL provide wr_addr, input, AW: write address; AW = $clog2(DEPTH).
REQ-010 SHALL provide wr_data, input, WIDTH: write data.
REQ-011 SHALL provide wr_be, input, WIDTH/8: byte enables; bit i gates wr_data[8i+7:8i].
REQ-012 SHALL provide rd_en, input, 1: read request.
REQ-013 SHALL provide rd_addr, input, AW: read address.
REQ-014 SHALL provide rd_data, output, WIDTH: read data.
REQ-015 SHALL provide rd_valid, output, 1: rd_data carries a fresh read result this cycle.
REQ-016 SHALL provide busy, output, 1: clear sequence in progress; requests are ignored.

Function
REQ-017 SHALL accept a write when wr_en=1 and busy=0; only bytes with wr_be set are updated; wr_be=0 leaves memory unchanged.
REQ-018 SHALL accept a read when rd_en=1 and busy=0; reads and writes are independent and may be accepted in the same cycle.
REQ-019 SHALL assert rd_valid for exactly one cycle per accepted read: 1 cycle after acceptance when OUT_REG=0, 2 cycles after when OUT_REG=1; back-to-back reads give back-to-back rd_valid pulses.
REQ-020 SHALL hold rd_data unchanged in cycles where rd_valid=0.
REQ-021 SHALL, on a same-cycle same-address read and write with RDW_MODE=0, return the pre-write word.
REQ-022 SHALL, on a same-cycle same-address read and write with RDW_MODE=1, return the merged word: enabled bytes from wr_data, other bytes from old content.
REQ-023 SHALL implement the clear controller as two states, IDLE and CLEAR.
REQ-024 SHALL, in CLEAR, write zero to one address per cycle, ascending from 0 to DEPTH-1, then move to IDLE; the clear takes exactly DEPTH cycles.
REQ-025 SHALL drive busy=1 in every CLEAR cycle and busy=0 from the first IDLE cycle onward.
REQ-026 SHALL ignore wr_en and rd_en while busy=1: no memory change and no rd_valid.
REQ-027 SHALL let any read accepted before busy rose complete its pipeline normally.
REQ-028 SHALL wrap no address: the clear counter stops at DEPTH-1; with a non-power-of-2 DEPTH, user addresses >= DEPTH are ignored for both writes and reads (no rd_valid).

Reset
REQ-029 SHALL, while rst=0 at a clock edge, set rd_data=0, rd_valid=0, flush the output pipeline and zero the clear counter.
REQ-030 SHALL enter CLEAR (busy=1) on the first edge after rst returns to 1 when CLEAR_ON_RST=1; otherwise enter IDLE (busy=0) and leave memory contents undefined.
REQ-031 SHALL, on reset asserted mid-clear, abort the clear and restart it from address 0 after release.
REQ-032 SHALL NOT reset the memory array through rst directly; clearing happens only through the CLEAR state.

Structure
REQ-033 SHALL place the RDW_MODE constants (RDW_READ_FIRST=0, RDW_WRITE_FIRST=1) and the clear-state enum in shared package lut_ram_pkg.
REQ-034 SHALL implement the clear FSM and counter as sub-module lut_ram_clear_ctrl; the array, byte-merge and read pipeline stay in lut_ram_2port.
REQ-035 SHALL keep the array free of reset logic so it maps to distributed/LUT RAM.

Verification
Bench parameters: WIDTH=32, DEPTH=16 unless stated.
REQ-036 SHALL cover post-reset clear: release rst -> busy=1 for exactly 16 cycles; then reads of addresses 0..15 return 0x00000000.
REQ-037 SHALL cover byte-enable write: write 0xAABBCCDD to addr 3 with be=4'b1111, then 0x11223344 with be=4'b0101 -> read of addr 3 returns 0xAA22CC44, rd_valid 1 cycle after rd_en (OUT_REG=0) or 2 cycles after (OUT_REG=1).
REQ-038 SHALL cover collision: addr 5 holds 0x0; same cycle write 0xFFFFFFFF (be=4'b1111) and read addr 5 -> rd_data=0x00000000 for RDW_MODE=0, 0xFFFFFFFF for RDW_MODE=1.
REQ-039 SHALL cover reset mid-clear: pull rst low at clear cycle 7, release -> busy=1 for a full 16 cycles again; rd_en pulsed during busy yields no rd_valid.
REQ-040 SHALL cover streaming: 16 consecutive reads of addrs 0..15 after writing data=addr -> 16 consecutive rd_valid pulses with data 0..15 in order.
REQ-041 SHALL cover non-power-of-2 DEPTH=12: write to addr 13 -> no memory change; read of addr 13 -> no rd_valid.
